// File: rtl/hex7seg_pkg.sv
// rtl/hex7seg_pkg.sv - shared types and segment constants for the hex 7-segment scan driver
package hex7seg_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } slot_state_t;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Active-high {g,f,e,d,c,b,a} patterns for 0..F
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex7seg_decode.sv
// rtl/hex7seg_decode.sv - combinational nibble-to-segment converter with blank override
module hex7seg_decode
    import hex7seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_OFF : SEG_LUT[nibble];

endmodule

// File: rtl/hex7seg_scan_driver.sv
// rtl/hex7seg_scan_driver.sv - multiplexed hex 7-segment driver, double-buffered load port
// Optional leading-zero suppression: define HEX7SEG_LZ_SUPPRESS_EN.
module hex7seg_scan_driver
    import hex7seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1024,
    parameter int BLANK_CYCLES = 16,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_blank,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    frame_tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0]            SEG_IDLE = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] EN_IDLE  = (ACTIVE_LOW != 0) ? '1 : '0;

    slot_state_t             state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [IDX_W-1:0]        idx, idx_n;

    logic [4*NUM_DIGITS-1:0] act_data, act_data_n;
    logic [NUM_DIGITS-1:0]   act_blank, act_blank_n;
    logic [4*NUM_DIGITS-1:0] pend_data, pend_data_n;
    logic [NUM_DIGITS-1:0]   pend_blank, pend_blank_n;
    logic                    pend_full, pend_full_n;

    logic                    last_cycle;
    logic                    last_digit;
    logic                    boundary;
    logic                    accept;
    logic                    tick_n;

    logic [NUM_DIGITS-1:0]   lz_dark;
    logic [3:0]              nib_mux;
    logic                    blank_mux;
    logic [6:0]              dec_seg;
    logic [6:0]              seg_n;
    logic [NUM_DIGITS-1:0]   en_n;

    assign last_cycle = (cnt == CNT_W'(SCAN_DIV - 1));
    assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
    assign boundary   = last_cycle && last_digit;
    assign accept     = load_valid && !pend_full;
    assign tick_n     = boundary;

    // Slot sequencing: counter, digit index and BLANK/DRIVE phase for the next cycle
    always_comb begin
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        state_n = state;
        if (last_cycle) begin
            cnt_n   = '0;
            idx_n   = last_digit ? '0 : idx + 1'b1;
            state_n = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
        end else if (state == ST_BLANK && 32'(cnt_n) >= 32'(BLANK_CYCLES)) begin
            state_n = ST_DRIVE;
        end
    end

    // Pending/active double buffer; accept and transfer never coincide since accept needs pending empty
    always_comb begin
        act_data_n   = act_data;
        act_blank_n  = act_blank;
        pend_data_n  = pend_data;
        pend_blank_n = pend_blank;
        pend_full_n  = pend_full;
        if (boundary && pend_full) begin
            act_data_n  = pend_data;
            act_blank_n = pend_blank;
            pend_full_n = 1'b0;
        end
        if (accept) begin
            pend_data_n  = load_data;
            pend_blank_n = load_blank;
            pend_full_n  = 1'b1;
        end
    end

`ifdef HEX7SEG_LZ_SUPPRESS_EN
    logic zero_run;

    // A digit goes dark only while it and every digit above it are unblanked zeros
    always_comb begin
        lz_dark  = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run && (act_data_n[k*4 +: 4] == 4'h0) && !act_blank_n[k];
            lz_dark[k] = zero_run;
        end
    end
`else
    assign lz_dark = '0;
`endif

    always_comb begin
        nib_mux   = 4'h0;
        blank_mux = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_n == IDX_W'(k)) begin
                nib_mux   = act_data_n[k*4 +: 4];
                blank_mux = act_blank_n[k] | lz_dark[k];
            end
        end
    end

    hex7seg_decode u_decode (
        .nibble (nib_mux),
        .blank  (blank_mux),
        .seg    (dec_seg)
    );

    assign seg_n = (state_n == ST_DRIVE) ? dec_seg : SEG_OFF;
    assign en_n  = (state_n == ST_DRIVE) ? (NUM_DIGITS'(1) << idx_n) : '0;

    // Outputs are registered from next-state values so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= '0;
            act_data   <= '0;
            act_blank  <= '1;
            pend_data  <= '0;
            pend_blank <= '1;
            pend_full  <= 1'b0;
            seg        <= SEG_IDLE;
            digit_en   <= EN_IDLE;
            load_ready <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            act_data   <= act_data_n;
            act_blank  <= act_blank_n;
            pend_data  <= pend_data_n;
            pend_blank <= pend_blank_n;
            pend_full  <= pend_full_n;
            seg        <= (ACTIVE_LOW != 0) ? ~seg_n : seg_n;
            digit_en   <= (ACTIVE_LOW != 0) ? ~en_n : en_n;
            load_ready <= !pend_full_n;
            frame_tick <= tick_n;
        end
    end

endmodule
